// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: producer request, synchronised read pointer,
// and everything the write controller hands to the memory and the read domain.
// Optional almost_full signal is present only when FIFO_ALMOST_FULL_EN is defined.
interface fifo_wr_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  winc;
  logic [ADDR_WIDTH:0]   rptr_gray_sync;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  inc;
  logic                  full;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;
`ifdef FIFO_ALMOST_FULL_EN
  logic                  almost_full;
`endif

  // Producer / surrounding logic side
  modport master (
    output winc,
    output rptr_gray_sync,
    input  w_addr,
    input  inc,
    input  full,
    input  wptr_gray,
    input  wr_level,
`ifdef FIFO_ALMOST_FULL_EN
    input  almost_full,
`endif
    input  overflow
  );

  // Write controller side
  modport slave (
    input  winc,
    input  rptr_gray_sync,
    output w_addr,
    output inc,
    output full,
    output wptr_gray,
    output wr_level,
`ifdef FIFO_ALMOST_FULL_EN
    output almost_full,
`endif
    output overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side control for the async FIFO: binary/Gray write pointer, registered full
// flag, write-side fill level and sticky overflow flag. The read pointer arrives as
// Gray code already synchronised into clk.
// Optional feature: define FIFO_ALMOST_FULL_EN to add a registered almost_full output
// (asserted when occupancy >= DEPTH - AF_MARGIN).
module fifo_wr_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3
`ifdef FIFO_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_MARGIN  = 1
`endif
) (
  input logic          clk,
  input logic          rst,
  fifo_wr_ctrl_if.slave bus
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wgray_q, wgray_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rgray_full;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                inc;

  // Gray-to-binary of the read pointer: bit i is the XOR of all Gray bits at or above i
  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      rbin[i] = ^(bus.rptr_gray_sync >> i);
    end
  end

  // Next pointer, full detection, level and overflow
  always_comb begin
    // full is registered, so a write in the cycle the reader frees a slot is still blocked
    inc        = bus.winc & ~full_q;
    wbin_d     = wbin_q + {{ADDR_WIDTH{1'b0}}, inc};
    wgray_d    = (wbin_d >> 1) ^ wbin_d;
    // Writer is a full lap ahead when its Gray pointer equals the read pointer with
    // the top two bits inverted
    rgray_full = {~bus.rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                  bus.rptr_gray_sync[ADDR_WIDTH-2:0]};
    full_d     = (wgray_d == rgray_full);
    level_d    = wbin_d - rbin;
    ovf_d      = ovf_q | (bus.winc & full_q);
  end

  // Pointer and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AfThresh = PtrW'(Depth - AF_MARGIN);

  logic af_q;

  // Almost-full uses the same next-cycle occupancy as wr_level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (level_d >= AfThresh);
    end
  end

  assign bus.almost_full = af_q;
`endif

  assign bus.w_addr    = wbin_q[ADDR_WIDTH-1:0];
  assign bus.inc       = inc;
  assign bus.full      = full_q;
  assign bus.wptr_gray = wgray_q;
  assign bus.wr_level  = level_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl (ADDR_WIDTH=3). A count-based model tracks accepted writes and
// the read count driving rptr_gray_sync; a negedge process compares all outputs with it.
module tb_fifo_wr_ctrl;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs   = 0;
  int errors = 0;

  // Model state: counts are plain integers, folded modulo 16 only when producing outputs
  int m_wcnt  = 0;
  int m_rcnt  = 0;
  int m_level = 0;
  bit m_full  = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_af    = 1'b0;
  bit chk_en  = 1'b0;

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs mid-cycle, advance the model, return just after the edge
  task automatic step(input bit w, input int r);
    int diff;
    @(negedge clk);
    #1;
    bus.winc           = w;
    m_rcnt             = r;
    bus.rptr_gray_sync = to_gray(r);
    if (w && m_full) m_ovf = 1'b1;
    if (w && !m_full) m_wcnt++;
    diff    = (m_wcnt - r) % 16;
    m_full  = (diff == 8);
    m_level = diff;
    m_af    = (diff >= 7);
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_wcnt  = 0;
    m_level = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    m_af    = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle with winc held high, released between edges
  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.winc = 1'b1;
    rst      = 1'b1;
    model_clear();
    #1;
    check("rst_async_waddr", 32'(bus.w_addr), 32'd0);
    check("rst_async_gray",  32'(bus.wptr_gray), 32'd0);
    check("rst_async_full",  32'(bus.full), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #3;
    rst                = 1'b0;
    bus.winc           = 1'b0;
    m_rcnt             = 0;
    bus.rptr_gray_sync = '0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("w_addr",    32'(bus.w_addr),    32'(m_wcnt % 8));
      check("wptr_gray", 32'(bus.wptr_gray), 32'(to_gray(m_wcnt)));
      check("full",      32'(bus.full),      32'(m_full));
      check("wr_level",  32'(bus.wr_level),  32'(m_level));
      check("overflow",  32'(bus.overflow),  32'(m_ovf));
      check("inc",       32'(bus.inc),       32'(bus.winc && !m_full));
`ifdef FIFO_ALMOST_FULL_EN
      check("almost_full", 32'(bus.almost_full), 32'(m_af));
`endif
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.winc           = 1'b1;
    bus.rptr_gray_sync = '0;
    #12;
    rst = 1'b0;
    bus.winc = 1'b0;
    chk_en = 1'b1;

    // 1. Reset in the middle of a burst
    step(1'b1, 0);
    step(1'b1, 0);
    check("pre_rst_waddr", 32'(bus.w_addr), 32'd2);
    do_reset();
    check("post_rst_waddr", 32'(bus.w_addr),    32'd0);
    check("post_rst_gray",  32'(bus.wptr_gray), 32'd0);
    check("post_rst_full",  32'(bus.full),      32'd0);
    check("post_rst_level", 32'(bus.wr_level),  32'd0);
    check("post_rst_ovf",   32'(bus.overflow),  32'd0);

    // 2. Fill from empty: addresses 0..7, then full
    for (int i = 0; i < 8; i++) begin
      check("fill_addr", 32'(bus.w_addr), 32'(i));
      step(1'b1, 0);
    end
    check("fill_gray",  32'(bus.wptr_gray), 32'b1100);
    check("fill_full",  32'(bus.full),      32'd1);
    check("fill_level", 32'(bus.wr_level),  32'd8);

    // 3. Writes while full are dropped and flagged
    for (int i = 0; i < 2; i++) begin
      check("ovf_inc", 32'(bus.inc), 32'd0);
      step(1'b1, 0);
      check("ovf_addr", 32'(bus.w_addr),    32'd0);
      check("ovf_gray", 32'(bus.wptr_gray), 32'b1100);
      check("ovf_flag", 32'(bus.overflow),  32'd1);
    end

    // 4. One read frees a slot; next write refills
    step(1'b0, 1);
    check("read1_full",  32'(bus.full),     32'd0);
    check("read1_level", 32'(bus.wr_level), 32'd7);
    step(1'b1, 1);
    check("refill_gray", 32'(bus.wptr_gray), 32'b1101);
    check("refill_full", 32'(bus.full),      32'd1);
    // Write and read advance in the same cycle while full: write blocked, full drops
    step(1'b1, 2);
    check("race_full",  32'(bus.full),      32'd0);
    check("race_gray",  32'(bus.wptr_gray), 32'b1101);
    check("race_level", 32'(bus.wr_level),  32'd7);
    check("race_ovf",   32'(bus.overflow),  32'd1);
    step(1'b0, 2);

    // 5. Wrap: 16 writes with the reader one behind
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, m_wcnt);
      if (i == 14) check("wrap_gray15", 32'(bus.wptr_gray), 32'b1000);
    end
    check("wrap_gray16", 32'(bus.wptr_gray), 32'b0000);
    check("wrap_full",   32'(bus.full),      32'd0);
    check("wrap_level",  32'(bus.wr_level),  32'd1);

`ifdef FIFO_ALMOST_FULL_EN
    // 6. Almost-full threshold at 7 entries
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 0);
    check("af_after7",   32'(bus.almost_full), 32'd1);
    check("full_after7", 32'(bus.full),        32'd0);
    step(1'b1, 0);
    check("full_after8", 32'(bus.full), 32'd1);
    step(1'b0, 1);
    check("af_after_read", 32'(bus.almost_full), 32'd1);
    check("full_after_read", 32'(bus.full), 32'd0);
`endif

    step(1'b0, m_rcnt);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errors);
    $finish;
  end
endmodule
